alu_issue_ctrl: RTL
===================

Name: alu_issue_ctrl

Overview:
Multi-cycle issue controller that drives the team's negedge-clocked ALU (ALUOp: 00 none, 01 ADD, 10 SUB, 11 AND).
- Accepts one 32-bit MIPS R-type instruction at a time over a valid/ready handshake.
- Decodes it into ALUOp, reads both source registers, presents operands to the ALU and captures the ALU result.
- Issues a single-cycle register-file writeback.
- Sits between fetch and the ALU/register file in the datapath.

Parameters:
DATA_W, 32, operand/result width.
REG_ADDR_W, 5, register address width.

Ports:
clock  in  1  system clock; FSM on posedge; ALU samples on negedge.
reset  in  1  asynchronous, active-high.
instr  in  32  instruction word; sampled on the accept edge.
instr_valid  in  1  instr is valid.
instr_ready  out  1  controller can accept an instruction.
rs_addr  out  REG_ADDR_W  register-file read address A, instr[25:21] of the held instruction.
rt_addr  out  REG_ADDR_W  register-file read address B, instr[20:16] of the held instruction.
rs_data  in  DATA_W  combinational read data A.
rt_data  in  DATA_W  combinational read data B.
alu_rs  out  DATA_W  ALU operand A (registered).
alu_rt  out  DATA_W  ALU operand B (registered).
alu_op  out  2  ALUOp to the ALU (registered).
alu_result  in  DATA_W  ALU result, updated by the ALU on negedge.
wb_en  out  1  register-file write strobe.
wb_addr  out  REG_ADDR_W  write address, instr[15:11].
wb_data  out  DATA_W  write data.
illegal  out  1  one-cycle pulse when an unsupported instruction is accepted.

Behaviour:
- Reset (async, active-high):
  - State goes to IDLE.
  - alu_rs, alu_rt, wb_data = 0; alu_op = 00; wb_en = 0; wb_addr = 0; illegal = 0; held instruction = 0.
  - instr_ready is decoded from state and is therefore 1 while in reset.
- States: IDLE, DECODE, EXEC, WB.
- instr_ready = 1 in IDLE and in WB; 0 in DECODE and EXEC.
- Accept: when instr_valid && instr_ready at a posedge, latch instr and go to DECODE. Without an accept, WB returns to IDLE.
- DECODE (one cycle):
  - rs_addr/rt_addr come from the held instruction.
  - On the exiting edge: alu_rs <= rs_data, alu_rt <= rt_data, alu_op <= decoded op.
- Decode rules:
  - opcode == 6'h00 and funct 6'h20 → 01; funct 6'h22 → 10; funct 6'h24 → 11.
  - Anything else is illegal.
- Illegal instruction:
  - alu_op stays 00; operands are not loaded.
  - illegal = 1 for exactly the cycle after DECODE.
  - Next state is IDLE; no writeback.
- EXEC (one cycle):
  - alu_op and operands are held stable; the ALU samples them on the mid-cycle negedge.
  - On the exiting edge: wb_data <= alu_result, wb_addr <= rd, and the state goes to WB.
- WB (one cycle):
  - wb_en = 1 unless rd == 0, in which case wb_en = 0 ($zero is never written).
  - alu_op returns to 00 on the edge leaving EXEC; it is 00 whenever the state is not EXEC.
- Latency and throughput:
  - Accept at edge N → wb_en high during the cycle after edge N+2.
  - Back-to-back throughput is one instruction per 3 cycles (accept in WB).
- Simultaneous events: an accept in WB overlaps the writeback; the new instruction's DECODE follows, so its register read sees the write committed at the end of WB.
- Reset mid-operation: the in-flight instruction is discarded with no writeback; wb_en and illegal drop immediately.
- Width: all arithmetic stays in the ALU; this block only moves DATA_W-bit values with no truncation or extension.
- instr_valid is ignored in DECODE and EXEC; the source must hold it until accepted.

Optional Feature:
- Macro: ISSUE_CNT_EN.
- Defined:
  - Adds outputs retired_cnt[31:0] and illegal_cnt[31:0], both reset to 0.
  - retired_cnt increments on every WB cycle, including rd == 0.
  - illegal_cnt increments on every illegal pulse.
  - Both counters wrap from 32'hFFFFFFFF to 0.
- Undefined: neither port nor counter logic exists; all other behaviour is identical.

Decomposition:
- Shared package alu_pkg holds:
  - ALUOp constants: ALU_NOP=2'b00, ALU_ADD=2'b01, ALU_SUB=2'b10, ALU_AND=2'b11.
  - OPC_RTYPE = 6'h00; FUNCT_ADD = 6'h20, FUNCT_SUB = 6'h22, FUNCT_AND = 6'h24.
  - The FSM state encoding.
- One combinational sub-module, alu_decode: instr[31:0] → alu_op[1:0], legal.

Test Plan:
- Reset release; rs_data=7, rt_data=5; instr ADD rd=3 (32'h00221820), valid 1 cycle → alu_op=01 in EXEC; wb_en=1, wb_addr=3, wb_data=12 exactly 3 cycles after accept; alu_op=00 after.
- SUB with rs_data=5, rt_data=7 → wb_data=32'hFFFFFFFE; AND with 32'hF0F0F0F0 & 32'h0FF00FF0 → 32'h00F000F0.
- Valid held continuously with ADD/SUB/AND stream → accepts every 3rd cycle (in WB), instr_ready low in DECODE/EXEC, three correct writebacks.
- instr with opcode 6'h08 or funct 6'h25 → illegal=1 for one cycle, wb_en never asserted, alu_op stays 00, back to IDLE.
- ADD with rd=0 → full sequence runs, wb_en stays 0; with ISSUE_CNT_EN, retired_cnt still increments.
- Assert reset during EXEC → outputs zero immediately, no wb_en pulse; next instruction after release completes normally.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared ALU issue definitions: ALUOp codes, R-type opcode/funct values and controller state encoding.
package alu_pkg;

    localparam logic [1:0] ALU_NOP = 2'b00;
    localparam logic [1:0] ALU_ADD = 2'b01;
    localparam logic [1:0] ALU_SUB = 2'b10;
    localparam logic [1:0] ALU_AND = 2'b11;

    localparam logic [5:0] OPC_RTYPE = 6'h00;
    localparam logic [5:0] FUNCT_ADD = 6'h20;
    localparam logic [5:0] FUNCT_SUB = 6'h22;
    localparam logic [5:0] FUNCT_AND = 6'h24;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DECODE = 2'd1,
        ST_EXEC   = 2'd2,
        ST_WB     = 2'd3
    } state_t;

endpackage

// File: rtl/alu_decode.sv
// Combinational R-type decoder: ADD/SUB/AND map to an ALUOp, everything else is flagged illegal.
module alu_decode
    import alu_pkg::*;
(
    input  logic [31:0] instr,
    output logic [1:0]  alu_op,
    output logic        legal
);

    logic [5:0] opcode;
    logic [5:0] funct;

    assign opcode = instr[31:26];
    assign funct  = instr[5:0];

    always_comb begin
        alu_op = ALU_NOP;
        legal  = 1'b0;
        if (opcode == OPC_RTYPE) begin
            case (funct)
                FUNCT_ADD: begin alu_op = ALU_ADD; legal = 1'b1; end
                FUNCT_SUB: begin alu_op = ALU_SUB; legal = 1'b1; end
                FUNCT_AND: begin alu_op = ALU_AND; legal = 1'b1; end
                default:   begin alu_op = ALU_NOP; legal = 1'b0; end
            endcase
        end
    end

endmodule

// File: rtl/alu_issue_ctrl.sv
// Multi-cycle ALU issue controller: accept -> DECODE -> EXEC -> WB, writeback 3 cycles after accept; next accept
// only in WB (one per 3 cycles), instr_valid ignored while busy. ISSUE_CNT_EN adds retired/illegal counters.
module alu_issue_ctrl
    import alu_pkg::*;
#(
    parameter int DATA_W     = 32,
    parameter int REG_ADDR_W = 5
) (
    input  logic                  clock,
    input  logic                  reset,
`ifdef ISSUE_CNT_EN
    output logic [31:0]           retired_cnt,
    output logic [31:0]           illegal_cnt,
`endif
    input  logic [31:0]           instr,
    input  logic                  instr_valid,
    output logic                  instr_ready,
    output logic [REG_ADDR_W-1:0] rs_addr,
    output logic [REG_ADDR_W-1:0] rt_addr,
    input  logic [DATA_W-1:0]     rs_data,
    input  logic [DATA_W-1:0]     rt_data,
    output logic [DATA_W-1:0]     alu_rs,
    output logic [DATA_W-1:0]     alu_rt,
    output logic [1:0]            alu_op,
    input  logic [DATA_W-1:0]     alu_result,
    output logic                  wb_en,
    output logic [REG_ADDR_W-1:0] wb_addr,
    output logic [DATA_W-1:0]     wb_data,
    output logic                  illegal
);

    state_t                state_q, state_d;
    logic [31:0]           instr_q, instr_d;
    logic [DATA_W-1:0]     alu_rs_q, alu_rs_d;
    logic [DATA_W-1:0]     alu_rt_q, alu_rt_d;
    logic [1:0]            alu_op_q, alu_op_d;
    logic [DATA_W-1:0]     wb_data_q, wb_data_d;
    logic [REG_ADDR_W-1:0] wb_addr_q, wb_addr_d;
    logic                  illegal_q, illegal_d;

    logic [1:0] dec_op;
    logic       dec_legal;
    logic       accept;

    alu_decode u_decode (
        .instr  (instr_q),
        .alu_op (dec_op),
        .legal  (dec_legal)
    );

    assign instr_ready = (state_q == ST_IDLE) || (state_q == ST_WB);
    assign accept      = instr_valid && instr_ready;

    always_comb begin
        state_d   = state_q;
        instr_d   = instr_q;
        alu_rs_d  = alu_rs_q;
        alu_rt_d  = alu_rt_q;
        alu_op_d  = alu_op_q;
        wb_data_d = wb_data_q;
        wb_addr_d = wb_addr_q;
        illegal_d = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    instr_d = instr;
                    state_d = ST_DECODE;
                end
            end
            ST_DECODE: begin
                if (dec_legal) begin
                    alu_rs_d = rs_data;
                    alu_rt_d = rt_data;
                    alu_op_d = dec_op;
                    state_d  = ST_EXEC;
                end else begin
                    illegal_d = 1'b1;
                    state_d   = ST_IDLE;
                end
            end
            ST_EXEC: begin
                // alu_result was refreshed by the ALU on the mid-cycle negedge
                wb_data_d = alu_result;
                wb_addr_d = instr_q[11 +: REG_ADDR_W];
                alu_op_d  = ALU_NOP;
                state_d   = ST_WB;
            end
            ST_WB: begin
                if (accept) begin
                    instr_d = instr;
                    state_d = ST_DECODE;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            instr_q   <= '0;
            alu_rs_q  <= '0;
            alu_rt_q  <= '0;
            alu_op_q  <= ALU_NOP;
            wb_data_q <= '0;
            wb_addr_q <= '0;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            instr_q   <= instr_d;
            alu_rs_q  <= alu_rs_d;
            alu_rt_q  <= alu_rt_d;
            alu_op_q  <= alu_op_d;
            wb_data_q <= wb_data_d;
            wb_addr_q <= wb_addr_d;
            illegal_q <= illegal_d;
        end
    end

    assign rs_addr = instr_q[21 +: REG_ADDR_W];
    assign rt_addr = instr_q[16 +: REG_ADDR_W];
    assign alu_rs  = alu_rs_q;
    assign alu_rt  = alu_rt_q;
    assign alu_op  = alu_op_q;
    assign wb_data = wb_data_q;
    assign wb_addr = wb_addr_q;
    assign illegal = illegal_q;
    // Strobe decoded from state so reset kills it immediately; $zero is never written
    assign wb_en   = (state_q == ST_WB) && (wb_addr_q != '0);

`ifdef ISSUE_CNT_EN
    logic [31:0] retired_cnt_q, retired_cnt_d;
    logic [31:0] illegal_cnt_q, illegal_cnt_d;

    always_comb begin
        retired_cnt_d = retired_cnt_q + {31'd0, (state_q == ST_WB)};
        illegal_cnt_d = illegal_cnt_q + {31'd0, illegal_q};
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            retired_cnt_q <= '0;
            illegal_cnt_q <= '0;
        end else begin
            retired_cnt_q <= retired_cnt_d;
            illegal_cnt_q <= illegal_cnt_d;
        end
    end

    assign retired_cnt = retired_cnt_q;
    assign illegal_cnt = illegal_cnt_q;
`endif

endmodule
